// File: rtl/cpu_pkg.sv
// Shared core definitions for the instruction fetch path.
//   XLEN / ILEN : address and instruction widths
//   PC_STEP     : sequential fetch increment (one 32-bit word)
//   fetch_state_e : fetch controller states
//   align_pc()  : clears the byte-offset bits of an address
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction queue holding {pc, instruction} pairs.
//   clk, rst      : clock, asynchronous active-high reset
//   push, wdata   : enqueue one entry
//   pop           : dequeue the head entry (caller only pops when count != 0)
//   flush         : empty the queue; dominates push and pop
//   count         : number of valid entries
//   head          : oldest entry (storage resets to zero so head reads 0 after reset)
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = XLEN + ILEN,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues sequential word-aligned fetches to the
// instruction memory, queues returned words with their PCs and presents
// them to decode. A redirect flushes the queue and marks every accepted,
// unreturned request as stale so its response is dropped.
//   clk, rst                         : clock, asynchronous active-high reset
//   mem_req, mem_addr, mem_ready     : request handshake to instruction memory
//   mem_rvalid, mem_rdata            : in-order responses (latency >= 1)
//   redirect_valid, redirect_pc      : restart fetch at a new address
//   inst_valid, inst_ready           : decode handshake
//   inst_data, inst_pc               : head instruction and its PC
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   FETCH | no stale responses outstanding; live responses are queued
//   DRAIN | discard_cnt stale responses still due; they are dropped
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [ILEN-1:0] mem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e          state;
    logic [XLEN-1:0]       fetch_pc;
    logic [XLEN-1:0]       resp_pc;
    logic [CW-1:0]         total_out;
    logic [CW-1:0]         discard_cnt;
    logic [CW-1:0]         count;
    logic [CW-1:0]         total_next;
    logic [CW:0]           credit_use;
    logic [XLEN+ILEN-1:0]  head;
    logic                  hs;
    logic                  rsp;
    logic                  pop;
    logic                  push;

    assign pop = inst_valid & inst_ready;

    // Every accepted request reserves a queue slot until it is consumed, so a
    // live response always finds room. The entry leaving this cycle already
    // frees its slot, which is what allows one fetch per cycle at DEPTH = 2.
    assign credit_use = {1'b0, total_out} + {1'b0, count} - {{CW{1'b0}}, pop};
    assign mem_req    = !rst && (credit_use < (CW + 1)'(DEPTH));
    assign mem_addr   = fetch_pc;
    assign hs         = mem_req & mem_ready;

    // A response with nothing outstanding cannot be legal; ignore it.
    assign rsp        = mem_rvalid && (total_out != '0);
    assign total_next = total_out + CW'(hs) - CW'(rsp);
    assign push       = rsp && (state == FETCH) && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            total_out   <= '0;
            discard_cnt <= '0;
        end else begin
            total_out <= total_next;
            if (redirect_valid) begin
                // Everything still outstanding after this cycle is stale,
                // including a request accepted right now.
                fetch_pc    <= align_pc(redirect_pc);
                resp_pc     <= align_pc(redirect_pc);
                discard_cnt <= total_next;
                state       <= (total_next != '0) ? DRAIN : FETCH;
            end else begin
                if (hs) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (rsp) begin
                    if (state == DRAIN) begin
                        discard_cnt <= discard_cnt - 1'b1;
                        if (discard_cnt == CW'(1)) begin
                            state <= FETCH;
                        end
                    end else begin
                        resp_pc <= resp_pc + PC_STEP;
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + ILEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({resp_pc, mem_rdata}),
        .count (count),
        .head  (head)
    );

    assign inst_valid = (count != '0);
    assign inst_pc    = head[XLEN+ILEN-1:ILEN];
    assign inst_data  = head[ILEN-1:0];

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: an in-order memory with random latency and random
// ready, random decode back-pressure and redirects. The reference is the
// architectural instruction stream: after reset or a redirect, decode must
// see consecutive words from the target onward, each carrying the word the
// memory holds at that address; issued addresses follow the same rule.
module tb_ifetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    ifetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // memory model
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc;
    int          lat_min = 1, lat_max = 1;
    int          rdy_pct = 100, irdy_pct = 100;

    // stream model
    logic [31:0] exp_issue, exp_pc, last_tgt;
    bit          post_redir;
    bit          chk_stream;
    int          n_hs, delivered, total_deliv;

    task automatic step(input bit redir, input logic [31:0] tgt);
        bit hs, xfer, rv;
        @(negedge clk);
        mem_ready      = ($urandom_range(99) < rdy_pct);
        inst_ready     = ($urandom_range(99) < irdy_pct);
        redirect_valid = redir;
        redirect_pc    = tgt;
        rv             = (pend_addr.size() != 0) && (pend_due[0] <= cyc);
        mem_rvalid     = rv;
        mem_rdata      = rv ? mem_word(pend_addr[0]) : $urandom;
        #1;
        if (post_redir) begin
            chk("redir_inst_valid", 32'(inst_valid), 32'd0);
            chk("redir_mem_addr", mem_addr, last_tgt);
            post_redir = 1'b0;
        end
        if (chk_stream && cyc >= 2) begin
            chk("stream_valid", 32'(inst_valid), 32'd1);
        end
        hs   = mem_req & mem_ready;
        xfer = inst_valid & inst_ready;
        if (hs) begin
            chk("issue_addr", mem_addr, exp_issue);
            exp_issue = exp_issue + 32'd4;
            n_hs++;
        end
        if (xfer) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_data", inst_data, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
            total_deliv++;
        end
        if (rv) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (hs) begin
            pend_addr.push_back(mem_addr);
            pend_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
        end
        chk("inflight_bound", 32'(pend_addr.size() <= DEPTH), 32'd1);
        if (redir) begin
            exp_pc     = tgt & ~32'h3;
            exp_issue  = tgt & ~32'h3;
            last_tgt   = tgt & ~32'h3;
            post_redir = 1'b1;
        end
        cyc++;
    endtask

    task automatic do_reset();
        #2;
        rst            = 1'b1;
        mem_ready      = 1'b0;
        mem_rvalid     = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        pend_addr.delete();
        pend_due.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rel_mem_req", 32'(mem_req), 32'd1);
        chk("rel_mem_addr", mem_addr, RESET_PC);
        exp_issue  = RESET_PC;
        exp_pc     = RESET_PC;
        cyc        = 0;
        n_hs       = 0;
        delivered  = 0;
        post_redir = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tgt;
        rst            = 1'b1;
        mem_ready      = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = '0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        total_deliv    = 0;
        do_reset();

        // full-rate streaming
        lat_min = 1; lat_max = 1; rdy_pct = 100; irdy_pct = 100;
        chk_stream = 1'b1;
        repeat (12) step(1'b0, 32'h0);
        chk_stream = 1'b0;
        chk("stream_count", 32'(delivered), 32'd10);

        // decode stalled from the start: only DEPTH fetches go out
        do_reset();
        irdy_pct = 0;
        repeat (6) step(1'b0, 32'h0);
        chk("stall_hs_count", 32'(n_hs), 32'd2);
        chk("stall_mem_req", 32'(mem_req), 32'd0);
        irdy_pct = 100;
        step(1'b0, 32'h0);
        chk("stall_resume_hs", 32'(n_hs), 32'd3);
        step(1'b0, 32'h0);
        chk("stall_released", 32'(delivered), 32'd2);

        // redirect with two requests in flight
        do_reset();
        lat_min = 4; lat_max = 4;
        repeat (2) step(1'b0, 32'h0);
        chk("two_in_flight", 32'(pend_addr.size()), 32'd2);
        step(1'b1, 32'h0000_0103);
        repeat (14) step(1'b0, 32'h0);
        chk("redir_delivered", 32'(delivered > 0), 32'd1);

        // redirect coinciding with a response and a new handshake
        do_reset();
        lat_min = 1; lat_max = 1;
        step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0200);
        repeat (8) step(1'b0, 32'h0);
        chk("redir_same_cycle_delivered", 32'(delivered > 0), 32'd1);

        // address wrap
        step(1'b1, 32'hFFFF_FFFA);
        repeat (10) step(1'b0, 32'h0);
        chk("wrap_delivered", 32'(delivered >= 8), 32'd1);

        // asynchronous reset with the queue occupied and a fetch outstanding
        do_reset();
        lat_min = 3; lat_max = 3; irdy_pct = 0;
        repeat (5) step(1'b0, 32'h0);
        chk("pre_rst_valid", 32'(inst_valid), 32'd1);
        do_reset();
        irdy_pct = 100;
        lat_min = 1; lat_max = 1;
        repeat (6) step(1'b0, 32'h0);

        // randomized traffic
        do_reset();
        for (int blk = 0; blk < 15; blk++) begin
            rdy_pct  = int'($urandom_range(30, 100));
            irdy_pct = int'($urandom_range(30, 100));
            lat_min  = 1;
            lat_max  = int'($urandom_range(1, 4));
            for (int k = 0; k < 200; k++) begin
                if ($urandom_range(99) < 3) begin
                    if ($urandom_range(1) == 0) tgt = $urandom;
                    else tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                    step(1'b1, tgt);
                end else begin
                    step(1'b0, 32'h0);
                end
            end
        end
        chk("random_progress", 32'(delivered >= 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
